// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end with prefetch queue
//
// Walks its own fetch pointer through instruction memory with at most one
// read outstanding, and buffers returned bytes (tagged with their address)
// in a DEPTH-entry queue for the decoder. A jump flushes the queue and
// redirects fetch; a read still in flight is drained and its byte dropped.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   jmp, jmp_addr        one-cycle redirect strobe and target
//   mem_req, mem_addr    read request / address, held until mem_ack
//   mem_ack, mem_data    read completion and returned byte
//   ins_valid/data/addr  queue head towards the decoder
//   ins_ready            decoder accepts the head
//   flush_cnt            bytes discarded by jumps, saturating
//                        (only with IFETCH_FLUSH_CNT_EN defined)
//
// Optional feature macro: IFETCH_FLUSH_CNT_EN
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RST_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jmp,
  input  logic [15:0] jmp_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        ins_valid,
  output logic [7:0]  ins_data,
  output logic [15:0] ins_addr,
  input  logic        ins_ready
`ifdef IFETCH_FLUSH_CNT_EN
  ,
  output logic [15:0] flush_cnt
`endif
);

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam int unsigned     CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t         state, state_nx;
  logic [15:0]    fa, fa_nx, addr_nx;
  logic           req_nx;
  logic [CW-1:0]  count, count_nx;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [7:0]     q_data [DEPTH];
  logic [15:0]    q_addr [DEPTH];
  logic           acked, push, pop;

  assign acked     = mem_req & mem_ack;
  assign push      = (state == FETCH) & acked & ~jmp;
  assign pop       = ins_valid & ins_ready & ~jmp;
  assign ins_valid = (count != '0);
  assign ins_data  = q_data[rd_ptr];
  assign ins_addr  = q_addr[rd_ptr];

  always_comb begin
    state_nx = state;
    fa_nx    = fa;
    count_nx = count;
    req_nx   = 1'b0;
    addr_nx  = mem_addr;
    if (jmp) begin
      fa_nx    = jmp_addr;
      count_nx = '0;
      // an unanswered read must still complete before the new stream starts
      state_nx = (mem_req & ~mem_ack) ? DRAIN : FETCH;
    end else begin
      if (push) fa_nx = fa + 16'd1;
      count_nx = count + CW'(push) - CW'(pop);
      if (state == DRAIN && acked) state_nx = FETCH;
    end
    // the request is registered so mem_req/mem_addr never move mid-access
    if (mem_req & ~mem_ack) begin
      req_nx  = 1'b1;
      addr_nx = mem_addr;
    end else begin
      req_nx  = (state_nx == FETCH) && (count_nx < FULL);
      addr_nx = fa_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      fa       <= RST_ADDR;
      count    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= RST_ADDR;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data[i] <= '0;
        q_addr[i] <= '0;
      end
    end else begin
      state    <= state_nx;
      fa       <= fa_nx;
      count    <= count_nx;
      mem_req  <= req_nx;
      mem_addr <= addr_nx;
      if (jmp) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_data[wr_ptr] <= mem_data;
          q_addr[wr_ptr] <= fa;
          wr_ptr         <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

`ifdef IFETCH_FLUSH_CNT_EN
  logic [16:0] flush_sum;

  // discarded bytes: a response that lands on a jump or during a drain,
  // plus every entry still queued when a jump hits
  always_comb begin
    flush_sum = {1'b0, flush_cnt} + 17'(acked & (jmp | (state == DRAIN)));
    if (jmp) flush_sum = flush_sum + 17'(count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_cnt <= '0;
    else        flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        ins_valid;
  logic [7:0]  ins_data;
  logic [15:0] ins_addr;
  logic        ins_ready;
`ifdef IFETCH_FLUSH_CNT_EN
  logic [15:0] flush_cnt;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   vectors   = 0;
  int   errors    = 0;
  int   lat       = 0;
  int   wc        = 0;
  int   exp_flush = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .RST_ADDR(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .ins_valid (ins_valid),
    .ins_data  (ins_data),
    .ins_addr  (ins_addr),
    .ins_ready (ins_ready)
`ifdef IFETCH_FLUSH_CNT_EN
    ,
    .flush_cnt (flush_cnt)
`endif
  );

  // memory: acks after 'lat' wait cycles, returns the low address byte
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (wc >= lat) begin
        mem_ack  = 1'b1;
        mem_data = mem_addr[7:0];
        wc       = 0;
      end else begin
        mem_ack = 1'b0;
        wc++;
      end
    end else begin
      mem_ack = 1'b0;
      wc      = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flush(input string tag);
`ifdef IFETCH_FLUSH_CNT_EN
    chk(tag, {16'h0, flush_cnt}, exp_flush);
`else
    if (tag.len() == 0) $display("flush tag empty");
`endif
  endtask

  task automatic expect_seq(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = start + 16'(i);
      sb.push_back({a, a[7:0]});
    end
  endtask

  // one clock: scoreboard pop at the falling edge, return just after rising edge
  task automatic tick();
    @(negedge clk);
    if (rst_n && ins_valid && ins_ready && !jmp && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pop", {8'h00, ins_addr, ins_data}, {8'h00, e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input int budget, input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    jmp       = 1'b0;
    jmp_addr  = 16'h0000;
    ins_ready = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ins_data", ins_data, 8'h00);
    chk("rst_ins_addr", ins_addr, 16'h0000);
    chk_flush("rst_flush");

    // zero-wait stream from reset
    expect_seq(16'h0000, 8);
    ins_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_valid_e1", ins_valid, 0);
    chk("t1_req_e1", mem_req, 1);
    tick();
    chk("t1_valid_e2", ins_valid, 1);
    wait_sb(30, "t1_stream");
    ins_ready = 1'b0;

    // fill to DEPTH, then one pop and one refill
    repeat (6) tick();
    chk("t2_full_req", mem_req, 0);
    chk("t2_full_addr", mem_addr, 16'h000C);
    chk("t2_head", {ins_addr, ins_data}, {16'h0008, 8'h08});
    expect_seq(16'h0008, 1);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk("t2_refill_req", mem_req, 1);
    chk("t2_refill_addr", mem_addr, 16'h000C);
    tick();
    chk("t2_refull_req", mem_req, 0);
    chk("t2_refull_addr", mem_addr, 16'h000D);
    chk("t2_refull_head", ins_addr, 16'h0009);
    expect_seq(16'h0009, 6);
    ins_ready = 1'b1;
    wait_sb(30, "t2_drain");
    ins_ready = 1'b0;

    // slow memory, jump during the second wait cycle
    repeat (6) tick();
    chk("t3_full_req", mem_req, 0);
    lat       = 3;
    ins_ready = 1'b1;
    jmp       = 1'b1;
    jmp_addr  = 16'h1000;
    exp_flush += 4;
    tick();
    jmp = 1'b0;
    chk("t3_j1_valid", ins_valid, 0);
    chk("t3_j1_addr", mem_addr, 16'h1000);
    chk_flush("t3_flush_full");
    tick();
    jmp      = 1'b1;
    jmp_addr = 16'h1234;
    tick();
    jmp = 1'b0;
    chk("t3_drain_req", mem_req, 1);
    chk("t3_drain_addr", mem_addr, 16'h1000);
    tick();
    chk("t3_hold_addr", mem_addr, 16'h1000);
    tick();
    exp_flush += 1;
    chk("t3_redirect_addr", mem_addr, 16'h1234);
    chk("t3_discard_valid", ins_valid, 0);
    chk_flush("t3_flush_drain");
    expect_seq(16'h1234, 3);
    wait_sb(60, "t3_stream");
    ins_ready = 1'b0;

    // jump with three queued bytes and a simultaneous ready
    lat = 0;
    repeat (10) tick();
    chk("t4_full_req", mem_req, 0);
    jmp       = 1'b1;
    jmp_addr  = 16'h4000;
    exp_flush += 4;
    tick();
    jmp = 1'b0;
    chk_flush("t4_flush_4000");
    tick();
    tick();
    tick();
    chk("t4_head3", {ins_valid, ins_addr}, {1'b1, 16'h4000});
    lat       = 2;
    ins_ready = 1'b1;
    jmp       = 1'b1;
    jmp_addr  = 16'h8000;
    tick();
    jmp = 1'b0;
    exp_flush += 3;
    chk("t4_no_pop_valid", ins_valid, 0);
    chk("t4_drain_addr", mem_addr, 16'h4003);
    chk_flush("t4_flush_q3");
    tick();
    tick();
    exp_flush += 1;
    chk("t4_redirect_addr", mem_addr, 16'h8000);
    chk_flush("t4_flush_drain");
    lat = 0;
    expect_seq(16'h8000, 3);
    wait_sb(20, "t4_stream");
    ins_ready = 1'b0;

    // address wrap
    repeat (8) tick();
    chk("t5_full_req", mem_req, 0);
    ins_ready = 1'b1;
    jmp       = 1'b1;
    jmp_addr  = 16'hFFFE;
    exp_flush += 4;
    tick();
    jmp = 1'b0;
    chk_flush("t5_flush");
    expect_seq(16'hFFFE, 4);
    wait_sb(20, "t5_wrap");
    ins_ready = 1'b0;

    // two jumps within one drain, then reset mid-request
    repeat (8) tick();
    chk("t6_full_req", mem_req, 0);
    lat       = 4;
    ins_ready = 1'b1;
    jmp       = 1'b1;
    jmp_addr  = 16'h1500;
    exp_flush += 4;
    tick();
    chk("t6_first_addr", mem_addr, 16'h1500);
    jmp_addr = 16'h2000;
    tick();
    jmp_addr = 16'h3000;
    tick();
    jmp = 1'b0;
    chk("t6_drain_addr", mem_addr, 16'h1500);
    chk_flush("t6_flush_mid");
    exp_flush += 1;
    expect_seq(16'h3000, 2);
    wait_sb(40, "t6_resume");
    chk_flush("t6_flush_end");
    chk("t6_inflight", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_flush = 0;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_addr", mem_addr, 16'h0000);
    chk("t6_rst_valid", ins_valid, 0);
    chk_flush("t6_rst_flush");
    lat = 0;
    tick();
    tick();
    expect_seq(16'h0000, 4);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sb(20, "t6_restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
